// File: rtl/inst_cache_pkg.sv
// inst_cache_pkg: shared widths, default geometry and FSM encodings for the instruction cache.
package inst_cache_pkg;
    localparam int XLEN = 32;
    localparam int DEF_ICACHE_SIZE_WIDTH = 6;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_e;
endpackage

// File: rtl/inst_cache_if.sv
// inst_cache_if: fetcher and memory-controller signals of the instruction cache.
interface inst_cache_if;
    import inst_cache_pkg::*;
    logic            rdy;
    logic            flush;
    logic            fet_icache_enable;
    logic [XLEN-1:0] fet_pc;
    logic            mem_fet_busy;
    logic            mem_inst_ready;
    logic [XLEN-1:0] mem_inst;
    logic [XLEN-1:0] mem_inst_addr;
    logic            icache_mem_enable;
    logic [XLEN-1:0] icache_mem_pc;
    logic            icache_busy;
    logic            icache_inst_ready;
    logic [XLEN-1:0] icache_inst;
    logic [XLEN-1:0] icache_inst_addr;
    modport slave (
        input  rdy, flush, fet_icache_enable, fet_pc, mem_fet_busy, mem_inst_ready, mem_inst, mem_inst_addr,
        output icache_mem_enable, icache_mem_pc, icache_busy, icache_inst_ready, icache_inst, icache_inst_addr
    );
    modport master (
        output rdy, flush, fet_icache_enable, fet_pc, mem_fet_busy, mem_inst_ready, mem_inst, mem_inst_addr,
        input  icache_mem_enable, icache_mem_pc, icache_busy, icache_inst_ready, icache_inst, icache_inst_addr
    );
endinterface

// File: rtl/inst_cache_array.sv
// icache_array: direct-mapped valid/tag/data storage with combinational read,
// synchronous write and synchronous clear of all valid bits (clear wins over write).
module icache_array
    import inst_cache_pkg::*;
#(
    parameter int IW = DEF_ICACHE_SIZE_WIDTH,
    parameter int TW = XLEN - IW - 1
) (
    input  logic            clk,
    input  logic            clr_i,
    input  logic            we_i,
    input  logic [IW-1:0]   widx_i,
    input  logic [TW-1:0]   wtag_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [IW-1:0]   ridx_i,
    output logic            rvalid_o,
    output logic [TW-1:0]   rtag_o,
    output logic [XLEN-1:0] rdata_o
);
    localparam int N = 1 << IW;
    logic [N-1:0]    valid_q;
    logic [TW-1:0]   tag_q  [N];
    logic [XLEN-1:0] data_q [N];
    always_ff @(posedge clk) begin
        if (clr_i) valid_q <= '0;
        else if (we_i) valid_q[widx_i] <= 1'b1;
    end
    always_ff @(posedge clk) begin
        if (we_i) begin
            tag_q[widx_i]  <= wtag_i;
            data_q[widx_i] <= wdata_i;
        end
    end
    assign rvalid_o = valid_q[ridx_i];
    assign rtag_o   = tag_q[ridx_i];
    assign rdata_o  = data_q[ridx_i];
endmodule

// File: rtl/inst_cache.sv
// inst_cache: direct-mapped instruction cache, one instruction per halfword-indexed entry.
// Optional hit/miss counters under `ICACHE_PERF_EN.
module inst_cache
    import inst_cache_pkg::*;
#(
    parameter int ICACHE_SIZE_WIDTH = DEF_ICACHE_SIZE_WIDTH
) (
    input  logic        clk,
    input  logic        rst,
    inst_cache_if.slave bus
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0] icache_hit_cnt,
    output logic [31:0] icache_miss_cnt
`endif
);
    localparam int TW = XLEN - ICACHE_SIZE_WIDTH - 1;
    state_e          state_q, state_d;
    logic [XLEN-1:0] miss_pc_q, miss_pc_d;
    logic [XLEN-1:0] inst_q, inst_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic            ready_q, ready_d;
    logic            rd_valid;
    logic [TW-1:0]   rd_tag;
    logic [XLEN-1:0] rd_data;
    logic            req, hit, fill, mem_en;
    assign req    = bus.fet_icache_enable && state_q == IDLE && !bus.flush;
    assign hit    = req && rd_valid && rd_tag == bus.fet_pc[XLEN-1:ICACHE_SIZE_WIDTH+1];
    assign fill   = state_q == WAIT && bus.mem_inst_ready && bus.mem_inst_addr == miss_pc_q;
    assign mem_en = state_q == REQ && !bus.mem_fet_busy && !bus.flush;
    // A fill coinciding with flush is still written: the data is correct, only the response is dropped.
    icache_array #(.IW(ICACHE_SIZE_WIDTH), .TW(TW)) u_array (
        .clk      (clk),
        .clr_i    (rst),
        .we_i     (fill && bus.rdy),
        .widx_i   (miss_pc_q[ICACHE_SIZE_WIDTH:1]),
        .wtag_i   (miss_pc_q[XLEN-1:ICACHE_SIZE_WIDTH+1]),
        .wdata_i  (bus.mem_inst),
        .ridx_i   (bus.fet_pc[ICACHE_SIZE_WIDTH:1]),
        .rvalid_o (rd_valid),
        .rtag_o   (rd_tag),
        .rdata_o  (rd_data)
    );
    always_comb begin
        state_d   = state_q;
        miss_pc_d = miss_pc_q;
        ready_d   = 1'b0;
        inst_d    = '0;
        addr_d    = '0;
        if (bus.flush) state_d = IDLE;
        else if (hit) begin
            ready_d = 1'b1;
            inst_d  = rd_data;
            addr_d  = bus.fet_pc;
        end else if (req) begin
            state_d   = REQ;
            miss_pc_d = bus.fet_pc;
        end else if (mem_en) state_d = WAIT;
        else if (fill) begin
            state_d = IDLE;
            ready_d = 1'b1;
            inst_d  = bus.mem_inst;
            addr_d  = miss_pc_q;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            miss_pc_q <= '0;
            ready_q   <= 1'b0;
            inst_q    <= '0;
            addr_q    <= '0;
        end else if (bus.rdy) begin
            state_q   <= state_d;
            miss_pc_q <= miss_pc_d;
            ready_q   <= ready_d;
            inst_q    <= inst_d;
            addr_q    <= addr_d;
        end
    end
    assign bus.icache_mem_enable = mem_en;
    assign bus.icache_mem_pc     = miss_pc_q;
    assign bus.icache_busy       = state_q != IDLE;
    assign bus.icache_inst_ready = ready_q;
    assign bus.icache_inst       = inst_q;
    assign bus.icache_inst_addr  = addr_q;
`ifdef ICACHE_PERF_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (bus.rdy) begin
            hit_cnt_q  <= hit_cnt_q + {31'd0, hit};
            miss_cnt_q <= miss_cnt_q + {31'd0, req && !hit};
        end
    end
    assign icache_hit_cnt  = hit_cnt_q;
    assign icache_miss_cnt = miss_cnt_q;
`endif
endmodule

// File: tb/tb_inst_cache.sv
// tb_inst_cache: table-driven fetch vectors plus hand-written stall/flush/fill sequences,
// with a response scoreboard checked at every icache_inst_ready pulse.
module tb_inst_cache;
    import inst_cache_pkg::*;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    inst_cache_if bus();
`ifdef ICACHE_PERF_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif
    inst_cache dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef ICACHE_PERF_EN
        ,
        .icache_hit_cnt  (hit_cnt),
        .icache_miss_cnt (miss_cnt)
`endif
    );
    typedef struct { logic [31:0] addr; logic [31:0] inst; } resp_t;
    typedef struct { logic [31:0] pc; logic [31:0] mem; logic [31:0] exp; bit miss; } vec_t;
    resp_t sb[$];
    int compared = 0, mismatched = 0, en_cnt = 0, resp_cnt = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic step;
        @(posedge clk);
        #1;
    endtask
    always @(negedge clk) begin
        resp_t e;
        en_cnt += int'(bus.icache_mem_enable);
        if (bus.icache_inst_ready) begin
            resp_cnt++;
            if (sb.size() == 0) chk("unexpected_resp_addr", bus.icache_inst_addr, 32'hffff_ffff);
            else begin
                e = sb.pop_front();
                chk("resp_addr", bus.icache_inst_addr, e.addr);
                chk("resp_inst", bus.icache_inst, e.inst);
            end
        end
    end
    task automatic mem_return(input logic [31:0] a, input logic [31:0] d, input int cycles);
        bus.mem_inst_ready = 1'b1;
        bus.mem_inst_addr  = a;
        bus.mem_inst       = d;
        repeat (cycles) step;
        bus.mem_inst_ready = 1'b0;
        bus.mem_inst_addr  = '0;
        bus.mem_inst       = '0;
    endtask
    task automatic wait_resp(input int r0, input string name);
        int n = 0;
        while (resp_cnt == r0 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(name, 32'(resp_cnt - r0), 32'd1);
    endtask
    task automatic no_resp(input int r0, input string name);
        repeat (3) step;
        chk(name, 32'(resp_cnt - r0), 32'd0);
    endtask
    task automatic request(input logic [31:0] pc);
        bus.fet_icache_enable = 1'b1;
        bus.fet_pc = pc;
        step;
        bus.fet_icache_enable = 1'b0;
    endtask
    task automatic fetch(input logic [31:0] pc, input logic [31:0] mem, input logic [31:0] exp, input bit miss);
        int e0 = en_cnt;
        int r0 = resp_cnt;
        int n = 0;
        sb.push_back('{pc, exp});
        request(pc);
        if (miss) begin
            while (!bus.icache_mem_enable && n < 20) begin
                step;
                n++;
            end
            chk("mem_pc", bus.icache_mem_pc, pc);
            step;
            mem_return(pc, mem, 1);
        end
        wait_resp(r0, "resp_arrived");
        chk("mem_en_cycles", 32'(en_cnt - e0), miss ? 32'd1 : 32'd0);
        step;
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        vec_t v[10];
        int r0, e0;
        v[0] = '{32'h0000_1000, 32'h0010_0093, 32'h0010_0093, 1'b1};
        v[1] = '{32'h0000_1000, 32'h0,         32'h0010_0093, 1'b0};
        v[2] = '{32'h0000_1080, 32'h0020_8113, 32'h0020_8113, 1'b1};
        v[3] = '{32'h0000_1080, 32'h0,         32'h0020_8113, 1'b0};
        v[4] = '{32'h0000_1000, 32'h0010_0093, 32'h0010_0093, 1'b1};
        v[5] = '{32'h0000_2002, 32'h0000_4501, 32'h0000_4501, 1'b1};
        v[6] = '{32'h0000_2002, 32'h0,         32'h0000_4501, 1'b0};
        v[7] = '{32'h0000_1004, 32'hdead_beef, 32'hdead_beef, 1'b1};
        v[8] = '{32'h0000_1004, 32'h0,         32'hdead_beef, 1'b0};
        v[9] = '{32'h0000_1000, 32'h0,         32'h0010_0093, 1'b0};
        rst = 1'b1;
        bus.rdy = 1'b1;
        bus.flush = 1'b0;
        bus.fet_icache_enable = 1'b0;
        bus.fet_pc = '0;
        bus.mem_fet_busy = 1'b0;
        bus.mem_inst_ready = 1'b0;
        bus.mem_inst = '0;
        bus.mem_inst_addr = '0;
        repeat (3) step;
        rst = 1'b0;
        step;
        chk("rst_mem_enable", {31'd0, bus.icache_mem_enable}, 32'd0);
        chk("rst_busy", {31'd0, bus.icache_busy}, 32'd0);
        chk("rst_inst_ready", {31'd0, bus.icache_inst_ready}, 32'd0);
        chk("rst_inst", bus.icache_inst, 32'd0);
        chk("rst_inst_addr", bus.icache_inst_addr, 32'd0);
        chk("rst_mem_pc", bus.icache_mem_pc, 32'd0);
        for (int i = 0; i < 10; i++) begin
            fetch(v[i].pc, v[i].mem, v[i].exp, v[i].miss);
`ifdef ICACHE_PERF_EN
            if (i == 0) begin
                chk("hit_cnt_first", hit_cnt, 32'd0);
                chk("miss_cnt_first", miss_cnt, 32'd1);
            end
`endif
        end
        // Controller busy for 5 cycles while the miss sits in REQ.
        e0 = en_cnt;
        r0 = resp_cnt;
        bus.mem_fet_busy = 1'b1;
        request(32'h0000_3000);
        repeat (5) begin
            chk("busy_hold_en", {31'd0, bus.icache_mem_enable}, 32'd0);
            step;
        end
        chk("busy_hold_busy", {31'd0, bus.icache_busy}, 32'd1);
        bus.mem_fet_busy = 1'b0;
        #1;
        chk("busy_drop_en", {31'd0, bus.icache_mem_enable}, 32'd1);
        step;
        chk("wait_en_low", {31'd0, bus.icache_mem_enable}, 32'd0);
        sb.push_back('{32'h0000_3000, 32'h1111_1111});
        mem_return(32'h0000_3000, 32'h1111_1111, 1);
        wait_resp(r0, "busy_resp");
        chk("busy_en_cycles", 32'(en_cnt - e0), 32'd1);
        step;
        // Flush during WAIT, then the stale return must be ignored and not filled.
        request(32'h0000_4000);
        step;
        chk("flush_wait_busy", {31'd0, bus.icache_busy}, 32'd1);
        r0 = resp_cnt;
        bus.flush = 1'b1;
        step;
        bus.flush = 1'b0;
        chk("flush_idle", {31'd0, bus.icache_busy}, 32'd0);
        mem_return(32'h0000_4000, 32'h4444_4444, 1);
        no_resp(r0, "flush_wait_no_resp");
        bus.flush = 1'b1;
        request(32'h0000_1000);
        bus.flush = 1'b0;
        no_resp(r0, "flush_req_ignored");
        chk("flush_req_busy", {31'd0, bus.icache_busy}, 32'd0);
        fetch(32'h0000_4000, 32'h4444_0000, 32'h4444_0000, 1'b1);
        // Flush coinciding with the fill: entry written, no response.
        request(32'h0000_5000);
        step;
        r0 = resp_cnt;
        bus.flush = 1'b1;
        mem_return(32'h0000_5000, 32'hcafe_f00d, 1);
        bus.flush = 1'b0;
        no_resp(r0, "flush_fill_no_resp");
        fetch(32'h0000_5000, 32'h0, 32'hcafe_f00d, 1'b0);
        // Foreign-address return ignored; held ready gives one response.
        request(32'h0000_6004);
        step;
        r0 = resp_cnt;
        mem_return(32'h0000_9998, 32'h0bad_0bad, 1);
        chk("foreign_addr_busy", {31'd0, bus.icache_busy}, 32'd1);
        chk("foreign_addr_no_resp", 32'(resp_cnt - r0), 32'd0);
        sb.push_back('{32'h0000_6004, 32'h1234_5678});
        mem_return(32'h0000_6004, 32'h1234_5678, 3);
        repeat (3) step;
        chk("held_ready_one_resp", 32'(resp_cnt - r0), 32'd1);
        fetch(32'h0000_6004, 32'h0, 32'h1234_5678, 1'b0);
`ifdef ICACHE_PERF_EN
        chk("hit_cnt_final", hit_cnt, 32'd7);
        chk("miss_cnt_final", miss_cnt, 32'd10);
`endif
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
